cr_osf_cqe_exit: RTL and testbench

//  OSF-side completion-queue-entry (CQE) egress stage. It is the responder end of the

---
 rtl/cr_osf_cqe_exit.sv | 144 ++++++++++++++
 tb/tb_cr_osf_cqe_exit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_osf_cqe_exit.sv
// OSF completion-queue-entry egress stage: buffers multi-word CQEs, honours the
// supervisor halt only on CQE boundaries, and reports every CQE that leaves.
module cr_osf_cqe_exit #(
    parameter int DEPTH = 8,
    parameter int CQE_W = 64,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cqe_in_valid,
    input  logic [CQE_W-1:0]           cqe_in_data,
    input  logic                       cqe_in_eop,
    output logic                       cqe_in_ready,
    output logic                       cqe_out_valid,
    output logic [CQE_W-1:0]           cqe_out_data,
    output logic                       cqe_out_eop,
    input  logic                       cqe_out_ready,
    input  logic                       sup_osf_halt,
    output logic                       osf_sup_cqe_exit,
    output logic                       osf_halted,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic [CNT_W-1:0]           cqe_exit_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } state_t;

    logic [CQE_W:0]     mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               exit_now;
    logic               in_cqe;
    logic               in_cqe_next;
    state_t             state;

    assign empty        = (level == '0);
    assign full         = (level == LVL_W'(DEPTH));
    assign cqe_in_ready = !rst && !full;
    assign push         = cqe_in_valid && cqe_in_ready;
    assign pop          = cqe_out_valid && cqe_out_ready;
    assign fifo_level   = level;

    assign {cqe_out_eop, cqe_out_data} = mem[rd_ptr];

    assign exit_now    = pop && cqe_out_eop;
    assign in_cqe_next = pop ? !cqe_out_eop : in_cqe;

    // A new CQE may not start while halt is requested; words of a started CQE keep flowing.
    always_comb begin
        cqe_out_valid = 1'b0;
        if (!rst && !empty) begin
            case (state)
                RUN:       cqe_out_valid = !(sup_osf_halt && !in_cqe);
                HALT_PEND: cqe_out_valid = 1'b1;
                default:   cqe_out_valid = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cqe_in_eop, cqe_in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Halt decisions use in_cqe_next so an eop leaving this cycle counts as a boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RUN;
            osf_halted       <= 1'b0;
            in_cqe           <= 1'b0;
            osf_sup_cqe_exit <= 1'b0;
            cqe_exit_cnt     <= '0;
        end else begin
            in_cqe           <= in_cqe_next;
            osf_sup_cqe_exit <= exit_now;
            if (exit_now) begin
                cqe_exit_cnt <= cqe_exit_cnt + CNT_W'(1);
            end
            case (state)
                RUN: begin
                    if (sup_osf_halt) begin
                        if (in_cqe_next) begin
                            state <= HALT_PEND;
                        end else begin
                            state      <= HALTED;
                            osf_halted <= 1'b1;
                        end
                    end
                end
                HALT_PEND: begin
                    if (!sup_osf_halt) begin
                        state <= RUN;
                    end else if (!in_cqe_next) begin
                        state      <= HALTED;
                        osf_halted <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!sup_osf_halt) begin
                        state      <= RUN;
                        osf_halted <= 1'b0;
                    end
                end
                default: begin
                    state      <= RUN;
                    osf_halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cr_osf_cqe_exit.sv
// Bench for cr_osf_cqe_exit: directed scenarios plus randomized traffic, checked by a
// scoreboard monitor against a queue-based reference of the egress rules.
module tb_cr_osf_cqe_exit;

    localparam int DEPTH = 8;
    localparam int CQE_W = 64;
    // Narrow counter so the wrap-around is reachable in a short run.
    localparam int CNT_W = 8;
    localparam int LVL_W = $clog2(DEPTH+1);

    logic               clk;
    logic               rst;
    logic               cqe_in_valid;
    logic [CQE_W-1:0]   cqe_in_data;
    logic               cqe_in_eop;
    logic               cqe_in_ready;
    logic               cqe_out_valid;
    logic [CQE_W-1:0]   cqe_out_data;
    logic               cqe_out_eop;
    logic               cqe_out_ready;
    logic               sup_osf_halt;
    logic               osf_sup_cqe_exit;
    logic               osf_halted;
    logic [LVL_W-1:0]   fifo_level;
    logic [CNT_W-1:0]   cqe_exit_cnt;

    cr_osf_cqe_exit #(.DEPTH(DEPTH), .CQE_W(CQE_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .cqe_in_valid     (cqe_in_valid),
        .cqe_in_data      (cqe_in_data),
        .cqe_in_eop       (cqe_in_eop),
        .cqe_in_ready     (cqe_in_ready),
        .cqe_out_valid    (cqe_out_valid),
        .cqe_out_data     (cqe_out_data),
        .cqe_out_eop      (cqe_out_eop),
        .cqe_out_ready    (cqe_out_ready),
        .sup_osf_halt     (sup_osf_halt),
        .osf_sup_cqe_exit (osf_sup_cqe_exit),
        .osf_halted       (osf_halted),
        .fifo_level       (fifo_level),
        .cqe_exit_cnt     (cqe_exit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             eop;
        logic [CQE_W-1:0] data;
    } word_t;

    word_t              exp_q[$];
    int                 checks = 0;
    int                 errors = 0;
    bit                 checking = 0;
    bit                 last_acc = 0;
    bit                 acc;
    int                 halt_hold = 0;

    // Reference state: mid-CQE flag, halted flag, pending exit pulse, exit count.
    bit                 m_in_cqe = 0;
    bit                 m_halted = 0;
    bit                 m_pulse = 0;
    logic [CNT_W-1:0]   m_cnt = '0;
    word_t              mon_w;
    bit                 mon_popped;
    bit                 mon_valid;
    bit                 mon_next_cqe;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock: note acceptance mid-cycle, record accepted word at the edge.
    task automatic cycle();
        @(negedge clk);
        acc = cqe_in_valid && cqe_in_ready;
        @(posedge clk);
        if (acc) exp_q.push_back(word_t'({cqe_in_eop, cqe_in_data}));
        last_acc = acc;
        #1;
    endtask

    task automatic sendWord(input logic eop, output logic [CQE_W-1:0] d);
        int n;
        cqe_in_valid = 1'b1;
        cqe_in_data  = {$urandom, $urandom};
        cqe_in_eop   = eop;
        d = cqe_in_data;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 200);
        if (!last_acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout actual=not_accepted expected=accepted");
        end
    endtask

    task automatic applyStimulus();
        if (last_acc || !cqe_in_valid) begin
            cqe_in_valid = ($urandom_range(9) < 7);
            cqe_in_data  = {$urandom, $urandom};
            cqe_in_eop   = ($urandom_range(2) == 0);
        end
        cqe_out_ready = ($urandom_range(9) < 7);
        if (halt_hold == 0) begin
            sup_osf_halt = ($urandom_range(3) == 0);
            halt_hold    = $urandom_range(40, 1);
        end else begin
            halt_hold--;
        end
        rst = ($urandom_range(399) == 0);
        cycle();
    endtask

    // Scoreboard monitor: expected outputs follow from FIFO contents and halt rules.
    always @(negedge clk) begin
        if (checking) begin
            mon_valid = !rst && !m_halted && (exp_q.size() > 0) && (m_in_cqe || !sup_osf_halt);
            checkOutput("in_ready", cqe_in_ready, !rst && (exp_q.size() != DEPTH));
            checkOutput("fifo_level", fifo_level, exp_q.size());
            checkOutput("out_valid", cqe_out_valid, mon_valid);
            checkOutput("osf_halted", osf_halted, m_halted);
            checkOutput("exit_pulse", osf_sup_cqe_exit, m_pulse);
            checkOutput("exit_cnt", cqe_exit_cnt, m_cnt);
            mon_popped = mon_valid && cqe_out_ready;
            if (mon_popped) begin
                mon_w = exp_q.pop_front();
                checkOutput("out_data", cqe_out_data, mon_w.data);
                checkOutput("out_eop", cqe_out_eop, mon_w.eop);
            end
            if (rst) begin
                exp_q.delete();
                m_in_cqe = 0;
                m_halted = 0;
                m_pulse  = 0;
                m_cnt    = '0;
            end else begin
                mon_next_cqe = mon_popped ? !mon_w.eop : m_in_cqe;
                m_halted = sup_osf_halt && !mon_next_cqe;
                m_pulse  = mon_popped && mon_w.eop;
                if (m_pulse) m_cnt = m_cnt + 1'b1;
                m_in_cqe = mon_next_cqe;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [CQE_W-1:0] d;
        logic [CQE_W-1:0] b1;
        logic [CNT_W-1:0] base;

        rst = 1'b1;
        cqe_in_valid = 1'b0;
        cqe_in_data = '0;
        cqe_in_eop = 1'b0;
        cqe_out_ready = 1'b0;
        sup_osf_halt = 1'b0;
        cycle();
        cycle();
        checking = 1;
        checkOutput("rst_in_ready", cqe_in_ready, 0);
        cycle();
        rst = 1'b0;
        cycle();
        checkOutput("ready_after_rst", cqe_in_ready, 1);
        checkOutput("cnt_after_rst", cqe_exit_cnt, 0);

        // Three-word CQE streaming straight through.
        cqe_out_ready = 1'b1;
        sendWord(1'b0, d);
        sendWord(1'b0, d);
        sendWord(1'b1, d);
        cqe_in_valid = 1'b0;
        repeat (4) cycle();
        checkOutput("cnt_after_A", cqe_exit_cnt, 1);

        // Fill to full, hold the ninth word, then pop with a simultaneous push.
        cqe_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) sendWord((i == 3) || (i == 7), d);
        checkOutput("level_full", fifo_level, 8);
        checkOutput("ready_full", cqe_in_ready, 0);
        cqe_in_valid = 1'b1;
        cqe_in_data  = {$urandom, $urandom};
        cqe_in_eop   = 1'b1;
        repeat (3) cycle();
        checkOutput("level_held", fifo_level, 8);
        cqe_out_ready = 1'b1;
        cycle();
        checkOutput("level_after_pop", fifo_level, 7);
        cycle();
        checkOutput("level_push_pop", fifo_level, 7);
        cqe_in_valid = 1'b0;
        repeat (10) cycle();

        // Halt arriving mid-CQE waits for the boundary, then blocks the next CQE.
        cqe_out_ready = 1'b0;
        sendWord(1'b0, d);
        sendWord(1'b0, d);
        sendWord(1'b1, d);
        sendWord(1'b0, b1);
        sendWord(1'b0, d);
        sendWord(1'b0, d);
        sendWord(1'b1, d);
        cqe_in_valid = 1'b0;
        cqe_out_ready = 1'b1;
        cycle();
        sup_osf_halt = 1'b1;
        checkOutput("pend_valid_A2", cqe_out_valid, 1);
        cycle();
        checkOutput("pend_valid_A3", cqe_out_valid, 1);
        checkOutput("pend_not_halted", osf_halted, 0);
        cycle();
        checkOutput("halted", osf_halted, 1);
        checkOutput("halted_no_valid", cqe_out_valid, 0);
        checkOutput("halted_exit_A", osf_sup_cqe_exit, 1);
        checkOutput("halted_level", fifo_level, 4);
        for (int i = 0; i < 20; i++) begin
            cycle();
            checkOutput("hold_no_valid", cqe_out_valid, 0);
            checkOutput("hold_no_exit", osf_sup_cqe_exit, 0);
        end
        sup_osf_halt = 1'b0;
        checkOutput("release_same_cycle", cqe_out_valid, 0);
        cycle();
        checkOutput("release_valid", cqe_out_valid, 1);
        checkOutput("release_B1", cqe_out_data, b1);
        repeat (8) cycle();

        // Back-to-back single-word CQEs, then a long burst across the counter wrap.
        base = m_cnt;
        for (int i = 0; i < 10; i++) sendWord(1'b1, d);
        cqe_in_valid = 1'b0;
        repeat (3) cycle();
        checkOutput("cnt_plus10", cqe_exit_cnt, CNT_W'(base + 8'd10));
        base = m_cnt;
        for (int i = 0; i < 260; i++) sendWord(1'b1, d);
        cqe_in_valid = 1'b0;
        repeat (3) cycle();
        checkOutput("cnt_wrap", cqe_exit_cnt, CNT_W'(base + 8'd4));

        // Reset with words queued and a CQE in progress.
        cqe_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) sendWord((i == 2) || (i == 5), d);
        cqe_in_valid = 1'b0;
        cqe_out_ready = 1'b1;
        cycle();
        cqe_out_ready = 1'b0;
        checkOutput("pre_rst_level", fifo_level, 5);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checkOutput("post_rst_level", fifo_level, 0);
        checkOutput("post_rst_valid", cqe_out_valid, 0);
        checkOutput("post_rst_exit", osf_sup_cqe_exit, 0);
        checkOutput("post_rst_halted", osf_halted, 0);
        cycle();

        // Randomized traffic with halts, backpressure and occasional resets.
        for (int i = 0; i < 4000; i++) applyStimulus();

        rst = 1'b0;
        sup_osf_halt = 1'b0;
        cqe_in_valid = 1'b0;
        cqe_out_ready = 1'b1;
        repeat (30) cycle();
        checkOutput("drained", fifo_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
